// File: rtl/conv_frame_sequencer.sv
// Frame-level controller for one 3x3 convolution unit: clears the unit, loads nine
// kernel weights, streams one frame of pixels and stores every result contiguously.
module conv_frame_sequencer #(
    parameter int DATA_WIDTH    = 32,
    parameter int IMG_W         = 28,
    parameter int IMG_H         = 28,
    parameter int ADDR_WIDTH    = 10,
    parameter int WADDR_WIDTH   = 8,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   start,
    input  logic [3:0]             kernel_sel,
    input  logic                   pause,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   wgt_rd_en,
    output logic [WADDR_WIDTH-1:0] wgt_addr,
    input  logic [DATA_WIDTH-1:0]  wgt_data,
    output logic [DATA_WIDTH-1:0]  weight_0,
    output logic [DATA_WIDTH-1:0]  weight_1,
    output logic [DATA_WIDTH-1:0]  weight_2,
    output logic [DATA_WIDTH-1:0]  weight_3,
    output logic [DATA_WIDTH-1:0]  weight_4,
    output logic [DATA_WIDTH-1:0]  weight_5,
    output logic [DATA_WIDTH-1:0]  weight_6,
    output logic [DATA_WIDTH-1:0]  weight_7,
    output logic [DATA_WIDTH-1:0]  weight_8,
    output logic                   pix_rd_en,
    output logic [ADDR_WIDTH-1:0]  pix_addr,
    input  logic [7:0]             pix_data,
    output logic                   conv_clr,
    output logic                   conv_valid_in,
    output logic [7:0]             conv_data_in,
    input  logic                   conv_valid_out,
    input  logic [7:0]             conv_data_out,
    output logic                   out_wr_en,
    output logic [ADDR_WIDTH-1:0]  out_addr,
    output logic [7:0]             out_data,
    output logic [2:0]             dbg_state
);

    localparam int N_PIX = IMG_W * IMG_H;
    localparam int N_OUT = (IMG_W - 2) * (IMG_H - 2);
    localparam int DCW   = $clog2(DRAIN_TIMEOUT + 1);

    localparam logic [ADDR_WIDTH-1:0] LAST_PIX  = ADDR_WIDTH'(N_PIX - 1);
    localparam logic [ADDR_WIDTH-1:0] OUT_LIMIT = ADDR_WIDTH'(N_OUT);
    localparam logic [DCW-1:0]        DRAIN_END = DCW'(DRAIN_TIMEOUT - 1);
    localparam logic [3:0]            WLOAD_END = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_WLOAD  = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [3:0]              kernel_q;
    logic [3:0]              wcnt_q;
    logic [ADDR_WIDTH-1:0]   pix_cnt_q;
    logic [ADDR_WIDTH-1:0]   out_cnt_q;
    logic [DCW-1:0]          drain_cnt_q;
    logic [DATA_WIDTH-1:0]   weight_q [9];

    logic accept_start;
    logic capture_window;
    logic drain_complete;
    logic drain_expired;

    assign accept_start   = (state_q == S_IDLE) && start;
    assign capture_window = (state_q == S_STREAM) || (state_q == S_DRAIN);
    // A write still in flight means out_cnt has already counted it; wait for it to land.
    assign drain_complete = (out_cnt_q == OUT_LIMIT) && !out_wr_en;
    assign drain_expired  = (drain_cnt_q == DRAIN_END);

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        done      = 1'b0;
        conv_clr  = 1'b0;
        wgt_rd_en = 1'b0;
        wgt_addr  = '0;
        pix_rd_en = 1'b0;
        pix_addr  = '0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                busy     = 1'b1;
                conv_clr = 1'b1;
                state_d  = S_WLOAD;
            end
            S_WLOAD: begin
                busy = 1'b1;
                if (wcnt_q != WLOAD_END) begin
                    wgt_rd_en = 1'b1;
                    wgt_addr  = WADDR_WIDTH'(kernel_q) * WADDR_WIDTH'(9)
                              + WADDR_WIDTH'(wcnt_q);
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                busy = 1'b1;
                if (!pause) begin
                    pix_rd_en = 1'b1;
                    pix_addr  = pix_cnt_q;
                    if (pix_cnt_q == LAST_PIX) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (drain_complete || drain_expired) state_d = S_DONE;
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Frame counters and the latched kernel index.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            kernel_q    <= '0;
            wcnt_q      <= '0;
            pix_cnt_q   <= '0;
            drain_cnt_q <= '0;
        end else begin
            if (accept_start) begin
                kernel_q    <= kernel_sel;
                wcnt_q      <= '0;
                pix_cnt_q   <= '0;
                drain_cnt_q <= '0;
            end
            if (state_q == S_WLOAD) wcnt_q <= wcnt_q + 4'd1;
            if (pix_rd_en) pix_cnt_q <= pix_cnt_q + 1'b1;
            if (state_q == S_DRAIN) drain_cnt_q <= drain_cnt_q + 1'b1;
        end
    end

    // Weight k arrives one cycle after its read, i.e. while wcnt_q == k+1.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            for (int i = 0; i < 9; i++) weight_q[i] <= '0;
        end else if ((state_q == S_WLOAD) && (wcnt_q != 4'd0)) begin
            weight_q[wcnt_q - 4'd1] <= wgt_data;
        end
    end

    assign weight_0 = weight_q[0];
    assign weight_1 = weight_q[1];
    assign weight_2 = weight_q[2];
    assign weight_3 = weight_q[3];
    assign weight_4 = weight_q[4];
    assign weight_5 = weight_q[5];
    assign weight_6 = weight_q[6];
    assign weight_7 = weight_q[7];
    assign weight_8 = weight_q[8];

    // Pixel memory returns data one cycle after the read; the strobe is delayed to match.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            conv_valid_in <= 1'b0;
        end else begin
            conv_valid_in <= pix_rd_en;
        end
    end

    assign conv_data_in = conv_valid_in ? pix_data : 8'd0;

    // Result capture and the sticky error flag.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            out_wr_en <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            out_cnt_q <= '0;
            err       <= 1'b0;
        end else begin
            out_wr_en <= 1'b0;
            if (accept_start) begin
                out_cnt_q <= '0;
                err       <= 1'b0;
            end
            if (capture_window && conv_valid_out) begin
                if (out_cnt_q != OUT_LIMIT) begin
                    out_wr_en <= 1'b1;
                    out_addr  <= out_cnt_q;
                    out_data  <= conv_data_out;
                    out_cnt_q <= out_cnt_q + 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end
            if ((state_q == S_DRAIN) && drain_expired && !drain_complete) err <= 1'b1;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Bench for conv_frame_sequencer: memory models, a stand-in convolution unit that
// feeds a scoreboard queue, a table of frame vectors and hand-written reset sequences.
module tb_conv_frame_sequencer;

    localparam int DW    = 32;
    localparam int IW    = 28;
    localparam int IH    = 28;
    localparam int AW    = 10;
    localparam int WAW   = 8;
    localparam int DT    = 64;
    localparam int N_PIX = IW * IH;
    localparam int N_OUT = (IW - 2) * (IH - 2);

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    kernel_sel = 4'd0;
    logic          pause = 1'b0;
    logic          busy, done, err;
    logic          wgt_rd_en;
    logic [WAW-1:0] wgt_addr;
    logic [DW-1:0] wgt_data = '0;
    logic [DW-1:0] weight_0, weight_1, weight_2, weight_3, weight_4;
    logic [DW-1:0] weight_5, weight_6, weight_7, weight_8;
    logic          pix_rd_en;
    logic [AW-1:0] pix_addr;
    logic [7:0]    pix_data = 8'd0;
    logic          conv_clr, conv_valid_in;
    logic [7:0]    conv_data_in;
    logic          conv_valid_out = 1'b0;
    logic [7:0]    conv_data_out = 8'd0;
    logic          out_wr_en;
    logic [AW-1:0] out_addr;
    logic [7:0]    out_data;
    logic [2:0]    dbg_state;

    logic [DW-1:0] w_out [9];
    logic [DW-1:0] wmem [256];
    logic [7:0]    pix_mem [1 << AW];
    logic [7:0]    exp_q [$];
    logic [7:0]    res_q [$];

    int checks = 0;
    int failures = 0;
    int res_limit = N_OUT;
    int res_extra = 0;

    conv_frame_sequencer #(
        .DATA_WIDTH(DW), .IMG_W(IW), .IMG_H(IH), .ADDR_WIDTH(AW),
        .WADDR_WIDTH(WAW), .DRAIN_TIMEOUT(DT)
    ) dut (
        .Clk(Clk), .Rst(Rst), .start(start), .kernel_sel(kernel_sel), .pause(pause),
        .busy(busy), .done(done), .err(err),
        .wgt_rd_en(wgt_rd_en), .wgt_addr(wgt_addr), .wgt_data(wgt_data),
        .weight_0(weight_0), .weight_1(weight_1), .weight_2(weight_2),
        .weight_3(weight_3), .weight_4(weight_4), .weight_5(weight_5),
        .weight_6(weight_6), .weight_7(weight_7), .weight_8(weight_8),
        .pix_rd_en(pix_rd_en), .pix_addr(pix_addr), .pix_data(pix_data),
        .conv_clr(conv_clr), .conv_valid_in(conv_valid_in), .conv_data_in(conv_data_in),
        .conv_valid_out(conv_valid_out), .conv_data_out(conv_data_out),
        .out_wr_en(out_wr_en), .out_addr(out_addr), .out_data(out_data),
        .dbg_state(dbg_state)
    );

    assign w_out[0] = weight_0;
    assign w_out[1] = weight_1;
    assign w_out[2] = weight_2;
    assign w_out[3] = weight_3;
    assign w_out[4] = weight_4;
    assign w_out[5] = weight_5;
    assign w_out[6] = weight_6;
    assign w_out[7] = weight_7;
    assign w_out[8] = weight_8;

    // Clock and registered-read memories.
    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (wgt_rd_en) wgt_data <= wmem[wgt_addr];
        if (pix_rd_en) pix_data <= pix_mem[pix_addr];
    end

    // Stand-in convolution unit: one result per complete 3x3 window, capped at
    // res_limit, then res_extra surplus results after the last pixel.
    int pix_idx = 0;
    int made = 0;
    int emitted = 0;
    always @(negedge Clk) begin
        if (!Rst || conv_clr) begin
            res_q.delete();
            pix_idx = 0;
            made = 0;
            emitted = 0;
            conv_valid_out = 1'b0;
            conv_data_out = 8'd0;
        end else begin
            if (conv_valid_in) begin
                if ((pix_idx % IW) >= 2 && (pix_idx / IW) >= 2 && made < res_limit) begin
                    res_q.push_back(conv_data_in + 8'(pix_idx));
                    made++;
                end
                pix_idx++;
                if (pix_idx == N_PIX)
                    for (int e = 0; e < res_extra; e++) res_q.push_back(8'hE0 + 8'(e));
            end
            if (res_q.size() > 0) begin
                conv_valid_out = 1'b1;
                conv_data_out = res_q.pop_front();
                if (emitted < N_OUT) exp_q.push_back(conv_data_out);
                emitted++;
            end else begin
                conv_valid_out = 1'b0;
                conv_data_out = 8'd0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] kernel;
        int         pause_at;
        int         pause_len;
        int         n_results;
        bit         start_in_wload;
        int         exp_writes;
        logic       exp_err;
        bit         exp_timeout;
    } vec_t;

    vec_t vecs [5];

    // Drives one frame from the current negedge and checks it cycle by cycle;
    // j counts negedges after the start edge T, so j==n observes the value at T+n.
    task automatic run_frame(input vec_t v);
        int j = 0, rd_cnt = 0, wr_cnt = 0, clr_cnt = 0, pause_left = 0;
        int last_rd_j = 0, last_wr_j = 0, done_j = 0;
        bit pause_started = 0, finished = 0;
        logic [7:0] exp_d;
        exp_q.delete();
        res_limit = (v.n_results < N_OUT) ? v.n_results : N_OUT;
        res_extra = (v.n_results > N_OUT) ? v.n_results - N_OUT : 0;
        start = 1'b1;
        kernel_sel = v.kernel;
        while (!finished && j < 4000) begin
            @(negedge Clk);
            j++;
            if (j == 1) start = 1'b0;
            if (v.start_in_wload && j == 5) begin
                start = 1'b1;
                kernel_sel = v.kernel + 4'd1;
            end
            if (v.start_in_wload && j == 6) start = 1'b0;
            if (v.pause_len > 0 && !pause_started && rd_cnt == v.pause_at) begin
                pause = 1'b1;
                pause_left = v.pause_len;
                pause_started = 1;
            end else if (pause) begin
                pause_left--;
                if (pause_left == 0) pause = 1'b0;
            end
            #1;
            if (j == 1) begin
                chk("clear_pulse", conv_clr, 1);
                chk("busy_rise", busy, 1);
                chk("err_cleared", err, 0);
            end
            if (j >= 2 && j <= 10) begin
                chk("wgt_rd_en", wgt_rd_en, 1);
                chk("wgt_addr", wgt_addr, (v.kernel * 9 + j - 2) % 256);
            end
            if (j == 11) chk("wgt_rd_end", wgt_rd_en, 0);
            if (j == 12) begin
                for (int k = 0; k < 9; k++) chk("weight_loaded", w_out[k], wmem[v.kernel * 9 + k]);
                chk("first_pix_rd", pix_rd_en, 1);
            end
            if (j == 13) chk("first_valid_in", conv_valid_in, 1);
            if (conv_clr) clr_cnt++;
            if (pause) chk("pause_blocks_read", pix_rd_en, 0);
            if (pause && pause_left == v.pause_len) begin
                chk("inflight_valid", conv_valid_in, 1);
                chk("inflight_data", conv_data_in, pix_mem[v.pause_at - 1]);
            end
            if (pix_rd_en) begin
                chk("pix_addr", pix_addr, rd_cnt);
                rd_cnt++;
                last_rd_j = j;
            end
            if (out_wr_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_extra: write at addr %0d, none expected", out_addr);
                end else begin
                    exp_d = exp_q.pop_front();
                    chk("out_data", out_data, exp_d);
                end
                chk("out_addr", out_addr, wr_cnt);
                wr_cnt++;
                last_wr_j = j;
            end
            if (done_j > 0) begin
                chk("busy_fall", busy, 0);
                chk("done_single", done, 0);
                finished = 1;
            end else if (done) begin
                done_j = j;
                chk("err_at_done", err, v.exp_err);
                for (int k = 0; k < 9; k++) chk("weight_held", w_out[k], wmem[v.kernel * 9 + k]);
            end
        end
        if (!finished) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout: no done after %0d cycles, required within 4000", j);
        end
        chk("rd_count", rd_cnt, N_PIX);
        chk("wr_count", wr_cnt, v.exp_writes);
        chk("clr_count", clr_cnt, 1);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("read_span", last_rd_j, 12 + N_PIX - 1 + v.pause_len);
        if (v.exp_timeout) chk("drain_timeout", done_j, last_rd_j + 1 + DT);
        else               chk("done_latency", done_j, last_wr_j + 2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        //           kernel pause_at len results wload writes err timeout
        vecs[0] = '{4'd2,  0,   0, N_OUT,     0, N_OUT,     1'b0, 0};
        vecs[1] = '{4'd2,  100, 5, N_OUT,     0, N_OUT,     1'b0, 0};
        vecs[2] = '{4'd7,  0,   0, 670,       0, 670,       1'b1, 1};
        vecs[3] = '{4'd3,  0,   0, 680,       1, N_OUT,     1'b1, 0};
        vecs[4] = '{4'd15, 0,   0, N_OUT,     0, N_OUT,     1'b0, 0};

        for (int i = 0; i < 256; i++) wmem[i] = $urandom() | 32'h1;
        for (int k = 0; k < 9; k++) wmem[18 + k] = 32'(k + 1);
        for (int i = 0; i < (1 << AW); i++) pix_mem[i] = 8'($urandom_range(0, 255));

        // Power-on reset.
        repeat (3) @(negedge Clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_pix_rd_en", pix_rd_en, 0);
        chk("rst_wgt_rd_en", wgt_rd_en, 0);
        chk("rst_out_wr_en", out_wr_en, 0);
        chk("rst_conv_clr", conv_clr, 0);
        chk("rst_weight_0", weight_0, 0);
        Rst = 1'b1;

        // First start lands on the first edge with reset released.
        run_frame(vecs[0]);

        // Reset in the middle of a frame.
        start = 1'b1;
        kernel_sel = 4'd1;
        @(negedge Clk);
        start = 1'b0;
        repeat (40) @(negedge Clk);
        #1;
        chk("pre_reset_streaming", pix_rd_en, 1);
        Rst = 1'b0;
        @(negedge Clk);
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_pix_rd_en", pix_rd_en, 0);
        chk("midrst_out_wr_en", out_wr_en, 0);
        chk("midrst_valid_in", conv_valid_in, 0);
        for (int k = 0; k < 9; k++) chk("midrst_weight", w_out[k], 0);
        @(negedge Clk);
        Rst = 1'b1;

        for (int i = 0; i < 5; i++) run_frame(vecs[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
